// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (inserts an even-parity bit, 8E1).
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    localparam int CLOCK_PER_BIT_DEF = 434;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; overflowing pushes and empty pops are ignored.
module uart_byte_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [7:0] r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_level = LW'(r_wptr - r_rptr);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 (or 8E1 with UART_TX_PARITY_EN) serialiser.
// state    | meaning
// IDLE     | line high, waiting for a buffered byte
// START    | start bit (low)
// DATA     | data bits, LSB first, index in r_bit
// PARITY   | even parity of the byte (UART_TX_PARITY_EN only)
// STOP     | stop bit (high); pops straight into the next frame if data is waiting
import uart_pkg::*;

module uart_tx_fifo #(
    parameter  int CLOCK_PER_BIT = CLOCK_PER_BIT_DEF,
    parameter  int FIFO_DEPTH    = 4,
    localparam int LW            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_tx,
    output logic          o_busy,
    output logic [LW-1:0] o_fifo_level
);

    localparam int CW = $clog2(CLOCK_PER_BIT);

    uart_state_t r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [2:0]    r_bit, w_bit_next;
    logic          r_tx, w_tx_next;
    logic          w_pop;
    logic          w_last;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_fifo_data;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_valid),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign w_last  = (r_cnt == CW'(CLOCK_PER_BIT - 1));
    assign o_ready = !w_full;
    assign o_tx    = r_tx;
    assign o_busy  = (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_last ? '0 : r_cnt + 1'b1;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_data;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_bit_next   = r_bit + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_last) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_last) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_data;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The line level is registered for the state being entered so o_tx changes on the transition edge.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_parity <= 1'b0;
        else if (w_pop) r_parity <= ^w_fifo_data;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB   = 434;
    localparam int DEPTH = 4;
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic [2:0] o_fifo_level;

    uart_tx_fifo #(.CLOCK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_fifo_level (o_fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d, input bit b2b);
        exp_t e;
        e.data = d;
        e.b2b  = b2b;
        exp_q.push_back(e);
    endtask

    // Called just after a push edge; busy rises on the following edge.
    task automatic wait_idle(input string name, input int budget);
        int n;
        @(posedge clk); #1;
        n = 1;
        while (o_busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(o_busy), 0);
    endtask

    // Line monitor: decodes frames at mid-bit and checks them against the scoreboard.
    initial begin : monitor
        logic       prev;
        logic [7:0] rx;
        logic       par;
        int         st;
        int         last_st;
        exp_t       e;
        prev    = 1'b1;
        last_st = -1000000;
        par     = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && prev && !o_tx) begin
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                chk("mon_start_bit", 32'(o_tx), 0);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rx[b] = o_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par = o_tx;
`endif
                repeat (CPB) @(negedge clk);
                chk("mon_stop_bit", 32'(o_tx), 1);
                chk("mon_frame_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("mon_byte", 32'(rx), 32'(e.data));
                    if (e.b2b) chk("mon_b2b_spacing", st - last_st, FRAME);
`ifdef UART_TX_PARITY_EN
                    chk("mon_parity", 32'(par), 32'(^e.data));
`endif
                end
                last_st = st;
            end
            prev = o_tx;
        end
    end

    initial begin : stim
        int t0;
        int lowlen;
        int busylen;
        int bad;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(o_tx), 1);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_level", 32'(o_fifo_level), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte 0xA5: latency, start-bit length, busy length.
        expect_byte(8'hA5, 1'b0);
        i_data = 8'hA5; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("a5_level_after_push", 32'(o_fifo_level), 1);
        chk("a5_tx_high_at_push", 32'(o_tx), 1);
        @(posedge clk); #1;
        chk("a5_tx_fall_next_edge", 32'(o_tx), 0);
        chk("a5_busy_rise", 32'(o_busy), 1);
        chk("a5_level_popped", 32'(o_fifo_level), 0);
        lowlen  = 0;
        busylen = 0;
        while (o_busy && busylen < FRAME + 100) begin
            busylen++;
            if (!o_tx && lowlen == busylen - 1) lowlen++;
            @(posedge clk); #1;
        end
        chk("a5_start_len", lowlen, CPB);
        chk("a5_busy_len", busylen, FRAME);
        chk("a5_tx_idle_after", 32'(o_tx), 1);

        // Two bytes 0x3C, 0xFF back to back.
        expect_byte(8'h3C, 1'b0);
        expect_byte(8'hFF, 1'b1);
        i_data = 8'h3C; i_valid = 1'b1;
        @(posedge clk); #1;
        i_data = 8'hFF;
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_idle("pair_idle_timeout", 3 * FRAME);
        chk("pair_queue_drained", exp_q.size(), 0);

        // 0x07: three ones, so even parity is 1 when parity is enabled.
        expect_byte(8'h07, 1'b0);
        i_data = 8'h07; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        t0 = cyc;
        wait_idle("x07_idle_timeout", 2 * FRAME);
        chk("x07_frame_len", cyc - t0 - 1, FRAME);

        // Burst 0x01..0x06 on consecutive edges; 0x06 meets a full FIFO.
        expect_byte(8'h01, 1'b0);
        for (int i = 2; i <= 5; i++) expect_byte(8'(i), 1'b1);
        t0 = 0;
        for (int i = 1; i <= 6; i++) begin
            i_data  = 8'(i);
            i_valid = 1'b1;
            if (i == 6) chk("burst_ready_when_full", 32'(o_ready), 0);
            else        chk("burst_ready_before_push", 32'(o_ready), 1);
            @(posedge clk); #1;
            if (i == 1) t0 = cyc;
        end
        i_valid = 1'b0;
        chk("burst_level_full", 32'(o_fifo_level), DEPTH);
        wait_idle("burst_idle_timeout", 6 * FRAME);
        chk("burst_total_len", cyc - t0 - 1, 5 * FRAME);
        chk("burst_queue_drained", exp_q.size(), 0);

        // Reset 1000 cycles into a frame with two bytes queued.
        mon_en = 1'b0;
        i_valid = 1'b1;
        i_data = 8'h11;
        @(posedge clk); #1;
        i_data = 8'h22;
        @(posedge clk); #1;
        i_data = 8'h33;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", 32'(o_busy), 1);
        chk("rst_mid_level_before", 32'(o_fifo_level), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(o_tx), 1);
        chk("rst_mid_level", 32'(o_fifo_level), 0);
        chk("rst_mid_ready", 32'(o_ready), 1);
        chk("rst_mid_busy", 32'(o_busy), 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (2 * FRAME) begin
            @(posedge clk); #1;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_fifo_level !== 3'd0) bad++;
        end
        chk("rst_no_resume", bad, 0);

        // Normal operation after reset.
        mon_en = 1'b1;
        expect_byte(8'h5A, 1'b0);
        i_data = 8'h5A; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_idle("post_rst_idle_timeout", 2 * FRAME);
        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter. It is the transmit-side counterpart of the UART receiver and sends 8N1 frames, LSB first, at CLOCK_PER_BIT clocks per bit, so its frames are directly receivable by that receiver. A small byte FIFO decouples the FFT result path from the serial line. Producers push bytes with a valid/ready handshake, and the block emits frames back-to-back whenever the FIFO holds data.

## Interface
- CLOCK_PER_BIT, 434, clocks per UART bit (50 MHz / 115200 baud); must be ≥ 4
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥ 2
- i_clk  input  1  system clock; all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- i_data  input  8  byte to transmit
- i_valid  input  1  i_data valid; accepted on an edge where i_valid && o_ready
- o_ready  output  1  FIFO not full; registered
- o_tx  output  1  serial line; idles high; registered
- o_busy  output  1  high while a frame is on the line (FSM not IDLE)
- o_fifo_level  output  $clog2(FIFO_DEPTH+1)  bytes currently buffered

## Operation
- Reset values: o_tx=1, o_ready=1, o_busy=0, o_fifo_level=0, FSM=IDLE, FIFO empty, bit counter=0.
- Push: a byte is written when i_valid && o_ready at an edge. When the FIFO is full, o_ready=0 and the write is ignored, even if a pop occurs on the same edge.
- FSM states and transitions:
  - IDLE: o_tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the counter, and go to START.
  - START: o_tx=0 for CLOCK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0] for CLOCK_PER_BIT cycles, then shift right and increment the index. After index 7, go to PARITY (macro on) or STOP.
  - PARITY: only when UART_TX_PARITY_EN is defined. o_tx = ^byte (even parity) for CLOCK_PER_BIT cycles, then go to STOP.
  - STOP: o_tx=1 for CLOCK_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit counter: width $clog2(CLOCK_PER_BIT). It counts 0..CLOCK_PER_BIT-1 and wraps to 0 on each bit boundary.
- FIFO: registered read and write pointers, one extra wrap bit each. Full when the pointers differ only in the MSB; empty when they are equal. o_fifo_level = wptr - rptr. A simultaneous push and pop leaves the level unchanged.
- Reset asserted mid-frame: the frame is truncated, o_tx goes high immediately, FIFO contents are discarded, and no partial frame resumes after reset release.
- i_data is sampled only on accepted edges. Holding i_valid high while o_ready=0 has no effect.

## Timing
- Latency: a byte accepted at edge k into an empty FIFO while in IDLE is popped at edge k+1, and o_tx falls at edge k+1.
- Frame length: 10·CLOCK_PER_BIT cycles (11· with parity). Every bit lasts exactly CLOCK_PER_BIT cycles.
- Back-to-back frames: the next start bit begins at the edge immediately after the last stop-bit cycle.
- o_busy rises with the start bit and falls on the edge returning to IDLE.
- o_ready deasserts on the edge after the write that fills the FIFO. It reasserts on the edge after a pop from a full FIFO.

## Configuration
- UART_TX_PARITY_EN defined: an even-parity bit is inserted between data bit 7 and the stop bit, giving an 11-bit frame (8E1).
- UART_TX_PARITY_EN undefined (default): the PARITY state is not compiled in and frames are 8N1. This matches the existing receiver.

## Structure
- Shared package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), default CLOCK_PER_BIT=434, and a frame-bits constant (10 or 11 depending on the macro).
- One sub-module: uart_byte_fifo (parameterised FIFO_DEPTH × 8 bits, push/pop, full/empty/level).
- The top level contains the FSM, the bit counter and the shift register.

## Test plan
- Single byte 0xA5 with CLOCK_PER_BIT=434 → o_tx low for 434 cycles, then bits 1,0,1,0,0,1,0,1 for 434 cycles each, then high for 434; o_busy high for exactly 4340 cycles.
- Loopback of o_tx into the UART receiver, sending 0x3C then 0xFF → receiver pulses its done flag with bytes 0x3C then 0xFF, and its error flag stays 0.
- Burst writes 0x01–0x06 on consecutive cycles with FIFO_DEPTH=4 → 0x01 popped at once; 0x02–0x05 buffered; o_ready=0 when 0x06 is offered, so 0x06 is never sent. Frames 0x01–0x05 are gap-free, 21700 cycles total.
- With UART_TX_PARITY_EN, send 0x07 → parity bit 1 after data bit 7; frame length 4774 cycles.
- Assert i_rst_n low 1000 cycles into a frame with 2 bytes queued → o_tx=1 immediately, o_fifo_level=0, o_ready=1; nothing transmits after release until a new push.
